// File: rtl/audio_seq_ctrl.sv
// rtl/audio_seq_ctrl.sv - WM8731 codec init plus slot-based record/playback sequencer
// Optional LOOP_PLAY_EN adds i_loop: playback wraps to the start of the track instead of stopping.
module audio_seq_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int N_INIT  = 6,
    parameter int N_SLOTS = 4,
    parameter int SPEED_W = 3,
    localparam int IDX_W  = (N_INIT > 1) ? $clog2(N_INIT) : 1,
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic [IDX_W-1:0]    o_init_idx,
    input  logic [23:0]         i_init_data,
    output logic                o_i2c_start,
    output logic [23:0]         o_i2c_data,
    input  logic                i_i2c_done,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic [SLOT_W-1:0]   i_slot,
    input  logic [SPEED_W-1:0]  i_speed,
    input  logic                i_slow,
`ifdef LOOP_PLAY_EN
    input  logic                i_loop,
`endif
    input  logic                i_sample_tick,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic                i_mem_ack,
    output logic [2:0]          o_state,
    output logic                o_full,
    output logic                o_done,
    output logic                o_overrun
);

    localparam int LOG_SLOTS = $clog2(N_SLOTS);
    localparam int OFF_W     = ADDR_W - LOG_SLOTS;
    localparam int PTR_W     = OFF_W + 1;
    localparam int SUM_W     = PTR_W + SPEED_W;
    localparam int CNT_W     = $clog2(N_INIT + 1);
    localparam logic [PTR_W-1:0] SLOT_SZ = PTR_W'(1) << OFF_W;

    localparam logic [1:0] CMD_STOP  = 2'd0;
    localparam logic [1:0] CMD_REC   = 2'd1;
    localparam logic [1:0] CMD_PLAY  = 2'd2;
    localparam logic [1:0] CMD_PAUSE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_INIT_WAIT  = 3'd1,
        ST_IDLE       = 3'd2,
        ST_REC        = 3'd3,
        ST_REC_PAUSE  = 3'd4,
        ST_PLAY       = 3'd5,
        ST_PLAY_PAUSE = 3'd6
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    idx_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [SPEED_W-1:0]  hold_q;
    logic [PTR_W-1:0]    len_q [N_SLOTS];
    logic                i2c_start_q;
    logic [23:0]         i2c_data_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                full_q;
    logic                done_q;
    logic                overrun_q;

    logic                loop_en;
    logic                cmd_fire;
    logic                ack_hit;
    logic                rec_mode;
    logic                play_mode;
    logic                rec_full;
    logic                play_end;
    logic                end_hit;
    logic                tick_issue;
    logic [PTR_W-1:0]    ptr_inc;
    logic [PTR_W-1:0]    cur_len;
    logic [PTR_W-1:0]    wrap_ptr;
    logic [ADDR_W-1:0]   addr_d;
    logic [SUM_W-1:0]    play_sum_d;
    logic [SPEED_W-1:0]  hold_d;

`ifdef LOOP_PLAY_EN
    assign loop_en = i_loop;
`else
    assign loop_en = 1'b0;
`endif

    assign o_init_idx  = IDX_W'(idx_q);
    assign o_i2c_start = i2c_start_q;
    assign o_i2c_data  = i2c_data_q;
    assign o_cmd_ready = (state_q != ST_INIT) && (state_q != ST_INIT_WAIT);
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_state     = state_q;
    assign o_full      = full_q;
    assign o_done      = done_q;
    assign o_overrun   = overrun_q;

    assign cmd_fire  = i_cmd_valid && o_cmd_ready;
    assign ack_hit   = i_mem_ack && mem_req_q;
    assign rec_mode  = (state_q == ST_REC) || (state_q == ST_REC_PAUSE);
    assign play_mode = (state_q == ST_PLAY) || (state_q == ST_PLAY_PAUSE);
    assign cur_len   = len_q[slot_q];
    assign ptr_inc   = ptr_q + PTR_W'(1);
    assign rec_full  = (ptr_inc == SLOT_SZ);
    assign play_end  = (play_sum_d >= SUM_W'(cur_len));
    assign wrap_ptr  = PTR_W'(play_sum_d - SUM_W'(cur_len));
    assign addr_d    = (ADDR_W'(slot_q) << OFF_W) + ADDR_W'(ptr_q);

    // An ack that ends the track takes priority over a same-cycle PAUSE/PLAY/REC command.
    assign end_hit = ack_hit && ((rec_mode && rec_full) ||
                                 (play_mode && play_end && !loop_en));

    assign tick_issue = i_sample_tick && !mem_req_q &&
                        ((state_q == ST_REC) || (state_q == ST_PLAY)) &&
                        !(cmd_fire && ((i_cmd == CMD_STOP) || (i_cmd == CMD_PAUSE)));

    // Slow mode repeats each sample i_speed+1 times; fast mode skips i_speed samples.
    always_comb begin
        play_sum_d = SUM_W'(ptr_q);
        hold_d     = hold_q;
        if (!i_slow) begin
            play_sum_d = SUM_W'(ptr_q) + SUM_W'(i_speed) + SUM_W'(1);
        end else if (hold_q == i_speed) begin
            play_sum_d = SUM_W'(ptr_q) + SUM_W'(1);
            hold_d     = '0;
        end else begin
            hold_d = hold_q + SPEED_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            slot_q      <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            for (int i = 0; i < N_SLOTS; i++) len_q[i] <= '0;
            i2c_start_q <= 1'b0;
            i2c_data_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            i2c_start_q <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (idx_q == CNT_W'(N_INIT)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        i2c_data_q  <= i_init_data;
                        i2c_start_q <= 1'b1;
                        state_q     <= ST_INIT_WAIT;
                    end
                end
                ST_INIT_WAIT: begin
                    if (i_i2c_done) begin
                        idx_q   <= idx_q + CNT_W'(1);
                        state_q <= ST_INIT;
                    end
                end
                default: begin
                    if (ack_hit) mem_req_q <= 1'b0;
                    if (cmd_fire && (i_cmd == CMD_STOP)) begin
                        state_q   <= ST_IDLE;
                        ptr_q     <= '0;
                        hold_q    <= '0;
                        overrun_q <= 1'b0;
                        mem_req_q <= 1'b0;
                    end else begin
                        if (i_sample_tick && mem_req_q) overrun_q <= 1'b1;
                        if (tick_issue) begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= (state_q == ST_REC);
                            mem_addr_q <= addr_d;
                        end
                        if (ack_hit && rec_mode) begin
                            len_q[slot_q] <= ptr_inc;
                            if (rec_full) begin
                                full_q  <= 1'b1;
                                state_q <= ST_IDLE;
                                ptr_q   <= '0;
                            end else begin
                                ptr_q <= ptr_inc;
                            end
                        end
                        if (ack_hit && play_mode) begin
                            hold_q <= hold_d;
                            if (!play_end) begin
                                ptr_q <= PTR_W'(play_sum_d);
                            end else begin
                                done_q <= 1'b1;
                                if (loop_en) begin
                                    ptr_q <= wrap_ptr;
                                end else begin
                                    state_q <= ST_IDLE;
                                    ptr_q   <= '0;
                                    hold_q  <= '0;
                                end
                            end
                        end
                        if (cmd_fire && !end_hit) begin
                            case (state_q)
                                ST_IDLE: begin
                                    if (i_cmd == CMD_REC) begin
                                        slot_q        <= i_slot;
                                        ptr_q         <= '0;
                                        len_q[i_slot] <= '0;
                                        state_q       <= ST_REC;
                                    end else if (i_cmd == CMD_PLAY) begin
                                        slot_q <= i_slot;
                                        ptr_q  <= '0;
                                        hold_q <= '0;
                                        if (len_q[i_slot] == '0) done_q <= 1'b1;
                                        else state_q <= ST_PLAY;
                                    end
                                end
                                ST_REC:        if (i_cmd == CMD_PAUSE) state_q <= ST_REC_PAUSE;
                                ST_REC_PAUSE:  if (i_cmd == CMD_REC)   state_q <= ST_REC;
                                ST_PLAY:       if (i_cmd == CMD_PAUSE) state_q <= ST_PLAY_PAUSE;
                                ST_PLAY_PAUSE: if (i_cmd == CMD_PLAY)  state_q <= ST_PLAY;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_seq_ctrl.sv
// tb/tb_audio_seq_ctrl.sv - scoreboard bench for audio_seq_ctrl: init words, memory accesses and pulses
module tb_audio_seq_ctrl;
    localparam int ADDR_W  = 6;
    localparam int N_INIT  = 6;
    localparam int N_SLOTS = 4;
    localparam int SPEED_W = 3;
    localparam int SLOT_SZ = 16;
    localparam int P_DONE  = 0;
    localparam int P_FULL  = 1;
    localparam logic [1:0] C_STOP = 2'd0, C_REC = 2'd1, C_PLAY = 2'd2, C_PAUSE = 2'd3;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [2:0]         o_init_idx;
    logic [23:0]        i_init_data;
    logic               o_i2c_start;
    logic [23:0]        o_i2c_data;
    logic               i_i2c_done = 1'b0;
    logic               i_cmd_valid = 1'b0;
    logic [1:0]         i_cmd = 2'd0;
    logic               o_cmd_ready;
    logic [1:0]         i_slot = 2'd0;
    logic [SPEED_W-1:0] i_speed = '0;
    logic               i_slow = 1'b0;
`ifdef LOOP_PLAY_EN
    logic               i_loop = 1'b0;
`endif
    logic               i_sample_tick = 1'b0;
    logic               o_mem_req;
    logic               o_mem_we;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic               i_mem_ack;
    logic               resp_ack = 1'b0;
    logic               man_ack = 1'b0;
    logic [2:0]         o_state;
    logic               o_full;
    logic               o_done;
    logic               o_overrun;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0]       i2c_q[$];
    logic [ADDR_W:0]   mem_q[$];
    int                pulse_q[$];
    int                model_len[N_SLOTS];
    bit                hold_ack = 1'b0;
    bit                manual = 1'b0;

    assign i_init_data = 24'h340815 + 24'(o_init_idx);
    assign i_mem_ack   = resp_ack | man_ack;

    always #5 i_clk = ~i_clk;

    audio_seq_ctrl #(.ADDR_W(ADDR_W), .N_INIT(N_INIT), .N_SLOTS(N_SLOTS), .SPEED_W(SPEED_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_init_idx(o_init_idx), .i_init_data(i_init_data),
        .o_i2c_start(o_i2c_start), .o_i2c_data(o_i2c_data), .i_i2c_done(i_i2c_done),
        .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
        .i_slot(i_slot), .i_speed(i_speed), .i_slow(i_slow),
`ifdef LOOP_PLAY_EN
        .i_loop(i_loop),
`endif
        .i_sample_tick(i_sample_tick),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .o_state(o_state), .o_full(o_full), .o_done(o_done), .o_overrun(o_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c, input int s);
        i_cmd_valid = 1'b1;
        i_cmd = c;
        i_slot = 2'(s);
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic tick();
        i_sample_tick = 1'b1;
        step();
        i_sample_tick = 1'b0;
        for (int n = 0; o_mem_req; n++) begin
            if (n == 100) begin
                report_fail("mem_timeout");
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 500 && o_state != 3'd2; n++) step();
        check("init_done_state", 32'(o_state), 2);
        check("init_cmd_ready", 32'(o_cmd_ready), 1);
        check("init_words_left", 32'(i2c_q.size()), 0);
    endtask

    task automatic rec_session(input int slot, input int n);
        int w;
        w = (n >= SLOT_SZ) ? SLOT_SZ : n;
        for (int i = 0; i < w; i++) mem_q.push_back({1'b1, ADDR_W'(slot * SLOT_SZ + i)});
        if (n >= SLOT_SZ) pulse_q.push_back(P_FULL);
        send_cmd(C_REC, slot);
        check("rec_state", 32'(o_state), 3);
        for (int i = 0; i < w; i++) tick();
        if (n >= SLOT_SZ) begin
            check("rec_full_idle", 32'(o_state), 2);
        end else begin
            send_cmd(C_STOP, slot);
            check("rec_stop_idle", 32'(o_state), 2);
        end
        model_len[slot] = w;
    endtask

    // Fast: every (speed+1)-th sample once. Slow: every sample speed+1 times.
    task automatic play_session(input int slot, input int speed, input bit slow, input int pause_at);
        int len, rep, stride, k;
        len = model_len[slot];
        rep = slow ? speed + 1 : 1;
        stride = slow ? 1 : speed + 1;
        k = 0;
        for (int p = 0; p < len; p += stride)
            for (int r = 0; r < rep; r++) begin
                mem_q.push_back({1'b0, ADDR_W'(slot * SLOT_SZ + p)});
                k++;
            end
        pulse_q.push_back(P_DONE);
        i_speed = SPEED_W'(speed);
        i_slow = slow;
        send_cmd(C_PLAY, slot);
        if (len == 0) begin
            check("play_empty_idle", 32'(o_state), 2);
            return;
        end
        check("play_state", 32'(o_state), 5);
        for (int i = 0; i < k; i++) begin
            if (i == pause_at) begin
                send_cmd(C_PAUSE, slot);
                check("pause_state", 32'(o_state), 6);
                for (int t = 0; t < 20; t++) begin
                    i_sample_tick = 1'b1;
                    step();
                    i_sample_tick = 1'b0;
                    check("pause_no_req", 32'(o_mem_req), 0);
                end
                send_cmd(C_PLAY, slot);
                check("resume_state", 32'(o_state), 5);
            end
            tick();
        end
        check("play_end_idle", 32'(o_state), 2);
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_i2c_start) begin
                if (i2c_q.size() == 0) report_fail("i2c_unexpected_start");
                else check("i2c_data", 32'(o_i2c_data), 32'(i2c_q.pop_front()));
                repeat (4) @(posedge i_clk);
                #1 i_i2c_done = 1'b1;
                @(posedge i_clk);
                #1 i_i2c_done = 1'b0;
            end
        end
    end

    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!o_mem_req) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (mem_q.size() == 0) report_fail("mem_unexpected_req");
                else check("mem_access", 32'({o_mem_we, o_mem_addr}), 32'(mem_q.pop_front()));
                if (!manual) begin
                    int n;
                    n = 0;
                    repeat ($urandom_range(0, 2)) @(posedge i_clk);
                    while (hold_ack && n < 1000) begin
                        @(posedge i_clk);
                        n++;
                    end
                    @(posedge i_clk);
                    #1 resp_ack = 1'b1;
                    @(posedge i_clk);
                    #1 resp_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_done) begin
                if (pulse_q.size() == 0) report_fail("unexpected_done");
                else check("pulse_done", 32'(pulse_q.pop_front()), 32'(P_DONE));
            end
            if (o_full) begin
                if (pulse_q.size() == 0) report_fail("unexpected_full");
                else check("pulse_full", 32'(pulse_q.pop_front()), 32'(P_FULL));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < N_SLOTS; s++) model_len[s] = 0;
        #1;
        check("rst_state", 32'(o_state), 0);
        check("rst_cmd_ready", 32'(o_cmd_ready), 0);
        check("rst_outputs", 32'({o_i2c_start, o_mem_req, o_mem_we, o_full, o_done, o_overrun}), 0);
        check("rst_addr", 32'(o_mem_addr), 0);
        check("rst_init_idx", 32'(o_init_idx), 0);
        for (int i = 0; i < N_INIT; i++) i2c_q.push_back(24'h340815 + 24'(i));
        repeat (3) step();
        i_rst = 1'b1;
        send_cmd(C_REC, 1);
        check("cmd_ignored_in_init", 32'(o_state < 3'd2), 1);
        wait_idle();

        play_session(3, 0, 1'b0, -1);
        rec_session(1, 10);
        play_session(1, 1, 1'b0, -1);
        play_session(1, 2, 1'b1, -1);
        play_session(1, 0, 1'b0, 4);
        rec_session(2, 20);
        tick();
        check("no_req_after_full", 32'(o_mem_req), 0);
        play_session(2, 3, 1'b0, -1);

        mem_q.push_back({1'b1, ADDR_W'(0)});
        send_cmd(C_REC, 0);
        hold_ack = 1'b1;
        i_sample_tick = 1'b1;
        step();
        i_sample_tick = 1'b0;
        step();
        check("ovr_req_pending", 32'(o_mem_req), 1);
        check("ovr_before", 32'(o_overrun), 0);
        i_sample_tick = 1'b1;
        step();
        i_sample_tick = 1'b0;
        check("ovr_set", 32'(o_overrun), 1);
        hold_ack = 1'b0;
        for (int n = 0; o_mem_req; n++) begin
            if (n == 100) begin
                report_fail("ovr_ack_timeout");
                break;
            end
            step();
        end
        check("ovr_sticky", 32'(o_overrun), 1);
        send_cmd(C_STOP, 0);
        check("ovr_cleared", 32'(o_overrun), 0);
        model_len[0] = 1;
        play_session(0, 0, 1'b0, -1);

        for (int i = 0; i < 6; i++) mem_q.push_back({1'b1, ADDR_W'(3 * SLOT_SZ + i)});
        send_cmd(C_REC, 3);
        for (int i = 0; i < 5; i++) tick();
        manual = 1'b1;
        i_sample_tick = 1'b1;
        step();
        i_sample_tick = 1'b0;
        step();
        check("stopack_req", 32'(o_mem_req), 1);
        man_ack = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd = C_STOP;
        step();
        man_ack = 1'b0;
        i_cmd_valid = 1'b0;
        check("stopack_req_drop", 32'(o_mem_req), 0);
        check("stopack_idle", 32'(o_state), 2);
        manual = 1'b0;
        model_len[3] = 5;
        play_session(3, 0, 1'b0, -1);

        for (int it = 0; it < 6; it++) begin
            int slot, n, spd, pa;
            bit slow;
            slot = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 15));
            slow = 1'($urandom_range(0, 1));
            spd = slow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
            pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
            rec_session(slot, n);
            play_session(slot, spd, slow, pa);
        end

        mem_q.push_back({1'b1, ADDR_W'(0)});
        send_cmd(C_REC, 0);
        tick();
        i_rst = 1'b0;
        #1;
        check("midrst_state", 32'(o_state), 0);
        check("midrst_ready", 32'(o_cmd_ready), 0);
        for (int s = 0; s < N_SLOTS; s++) model_len[s] = 0;
        for (int i = 0; i < N_INIT; i++) i2c_q.push_back(24'h340815 + 24'(i));
        step();
        i_rst = 1'b1;
        wait_idle();
        play_session(1, 0, 1'b0, -1);

        repeat (10) step();
        check("mem_q_drained", 32'(mem_q.size()), 0);
        check("pulse_q_drained", 32'(pulse_q.size()), 0);
        check("i2c_q_drained", 32'(i2c_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_seq_ctrl.md
Name: audio_seq_ctrl

Overview:
Parametrised record/playback sequencer for the WM8731 audio path. It runs the codec I2C init sequence, then accepts record, play, pause and stop commands. It drives a word-addressed sample memory split into N_SLOTS independent tracks, with per-track recorded length and fast/slow playback. It sits between the top-level switch/key decode, the I2C sender and the SRAM manager.

Parameters:
ADDR_W, 20, sample memory word-address width
N_INIT, 6, number of 24-bit codec init words
N_SLOTS, 4, number of track slots; power of 2, >=1
SPEED_W, 3, speed field width; factor = i_speed+1

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
o_init_idx  out  $clog2(N_INIT)  index into external init ROM
i_init_data  in  24  init word at o_init_idx (combinational lookup)
o_i2c_start  out  1  one-cycle start pulse to I2C sender
o_i2c_data  out  24  word to send; held stable until i_i2c_done
i_i2c_done  in  1  one-cycle pulse when the word has been sent
i_cmd_valid  in  1  command strobe
i_cmd  in  2  0=STOP 1=REC 2=PLAY 3=PAUSE
o_cmd_ready  out  1  high when commands are accepted
i_slot  in  $clog2(N_SLOTS) (min 1)  track select, sampled on REC/PLAY from IDLE
i_speed  in  SPEED_W  speed factor minus one
i_slow  in  1  1 = slow playback, 0 = fast
i_sample_tick  in  1  one pulse per audio frame (LRCK edge)
o_mem_req  out  1  memory request; held until ack
o_mem_we  out  1  1 = write (record), 0 = read (play)
o_mem_addr  out  ADDR_W  slot base + pointer
i_mem_ack  in  1  one-cycle access-complete pulse
o_state  out  3  current state code
o_full  out  1  one-cycle pulse: record hit slot end
o_done  out  1  one-cycle pulse: playback reached recorded length
o_overrun  out  1  sticky: tick arrived while request pending; cleared by STOP

Behaviour:
- State codes: INIT=0, INIT_WAIT=1, IDLE=2, REC=3, REC_PAUSE=4, PLAY=5, PLAY_PAUSE=6.
- Reset values:
  - state INIT; init index 0; all pointers and slot lengths 0.
  - o_i2c_start, o_mem_req, o_mem_we, o_full, o_done, o_overrun 0; o_mem_addr 0; o_cmd_ready 0.
- Init sequence:
  - INIT with index < N_INIT: drive o_i2c_data = i_init_data, pulse o_i2c_start for one cycle, go to INIT_WAIT.
  - INIT_WAIT on i_i2c_done: index++, return to INIT.
  - INIT with index == N_INIT: go to IDLE.
  - Commands are ignored throughout INIT and INIT_WAIT.
- o_cmd_ready = 1 in every state except INIT and INIT_WAIT. A command is consumed the cycle i_cmd_valid && o_cmd_ready.
- Slot geometry:
  - SLOT_SZ = 2^ADDR_W / N_SLOTS; base = slot * SLOT_SZ.
  - Pointer and lengths are ADDR_W - log2(N_SLOTS) + 1 bits wide.
- Command transitions (any transition not listed is ignored):
  - IDLE + REC: latch slot, ptr = 0, len[slot] = 0, go to REC.
  - IDLE + PLAY: latch slot, ptr = 0, go to PLAY. If len[slot] == 0, go straight to IDLE with an o_done pulse.
  - REC + PAUSE: go to REC_PAUSE. REC_PAUSE + REC: go to REC.
  - PLAY + PAUSE: go to PLAY_PAUSE. PLAY_PAUSE + PLAY: go to PLAY.
  - STOP from any post-init state: go to IDLE, ptr = 0, clear o_overrun. A recording keeps len = ptr at stop.
- REC:
  - On tick: o_mem_req = 1, o_mem_we = 1, addr = base + ptr.
  - On ack: ptr++, len[slot] = ptr + 1.
  - When len reaches SLOT_SZ: one o_full pulse, go to IDLE.
- PLAY:
  - On tick: read at base + ptr.
  - On ack, fast mode (i_slow=0): ptr += i_speed + 1.
  - On ack, slow mode: a hold counter counts acks; ptr += 1 when hold == i_speed, then hold = 0. i_speed=0 means normal speed.
  - If the new ptr >= len[slot]: one o_done pulse, go to IDLE.
- Pause states issue no new requests. An outstanding request still completes; the pointer update on its ack still applies.
- A tick with o_mem_req already high is dropped and sets o_overrun.
- Simultaneous STOP and ack: STOP wins. The ack is consumed, the pointer is not advanced, and o_mem_req drops next cycle.
- Reset mid-operation: asynchronously returns to INIT and re-runs the full codec init.

Optional Feature:
LOOP_PLAY_EN:
- Defined: adds input i_loop (1 bit). In PLAY with i_loop=1, reaching len wraps ptr to (new ptr - len), pulses o_done, and stays in PLAY.
- Undefined: no i_loop port; playback always stops at len.

Test Plan:
- Reset with N_INIT=6 and a ROM returning 0x340815+idx; done asserted 5 cycles after each start -> six start pulses with data 0x340815..0x34081A, then o_state=2 and o_cmd_ready=1.
- REC slot 1 for 10 ticks (ack 2 cycles later), then STOP -> addresses 0x40000..0x40009 written, len[1]=10, state IDLE.
- PLAY slot 1, i_speed=1, i_slow=0 -> reads at 0x40000, 0x40002 … 0x40008; o_done pulse after the 5th ack; IDLE.
- PLAY slot 1, i_speed=2, i_slow=1 -> each address read 3 times; o_done after 30 acks.
- REC with ADDR_W=6, N_SLOTS=4 -> o_full pulses after 16 writes; second tick while ack withheld -> o_overrun=1 until STOP.
- PAUSE during PLAY at ptr=4, 20 idle ticks, then PLAY -> no requests while paused; resumes at base+4. With LOOP_PLAY_EN and i_loop=1, wrap to base+0 with o_done pulse.
